// File: rtl/posit_add_scheduler.sv
// posit_add_scheduler
// Shares one pipelined posit adder between NREQ requesters. A round-robin
// arbiter grants at most one request per cycle and drives the adder
// operands. A LATENCY-deep {valid, tag} pipeline tracks each issued
// operation so the returning result can be tagged with its requester.
//
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_valid_i              per-requester request
//   req_in1_i, req_in2_i     per-requester operands, slice i = [32i+31:32i]
//   req_ready_o              one-hot (or zero) grant
//   add_in1_o/add_in2_o      operands to the shared adder
//   add_start_o              issue strobe to the adder
//   add_result_i, add_inf_i, add_zero_i, add_done_i   adder return path
//   res_valid_o, res_tag_o, res_data_o, res_inf_o, res_zero_o   tagged result
//   in_flight_o              operations issued but not yet returned
//   err_o                    sticky protocol error (add_done disagreement)
module posit_add_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*32-1:0]   req_in1_i,
    input  logic [NREQ*32-1:0]   req_in2_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [31:0]          add_in1_o,
    output logic [31:0]          add_in2_o,
    output logic                 add_start_o,
    input  logic [31:0]          add_result_i,
    input  logic                 add_inf_i,
    input  logic                 add_zero_i,
    input  logic                 add_done_i,
    output logic                 res_valid_o,
    output logic [2:0]           res_tag_o,
    output logic [31:0]          res_data_o,
    output logic                 res_inf_o,
    output logic                 res_zero_o,
    output logic [2:0]           in_flight_o,
    output logic                 err_o
);

    localparam int IW = $clog2(LATENCY + 1);

    logic [2:0]              last_grant_q, last_grant_d;
    logic [LATENCY-1:0]      pv_q, pv_d;
    logic [LATENCY-1:0][2:0] pt_q, pt_d;
    logic [2:0]              in_flight_q, in_flight_d;
    logic                    err_q, err_d;
    logic [IW-1:0]           ign_q, ign_d;

    logic [NREQ-1:0]         vld;
    logic [NREQ-1:0]         rot;
    logic [3:0]              base;
    logic [3:0]              sum;
    logic                    found;
    logic [2:0]              gnt_idx;
    logic                    emerge_v;
    logic [2:0]              emerge_t;

    // An unknown request bit is treated as no request; reset blocks all grants.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = (req_valid_i[i] === 1'b1) && !reset_i;
        end
    end

    // Rotate the request vector so that the highest-priority requester
    // lands at bit 0, pick the lowest set bit, then rotate the index back.
    always_comb begin
        base  = {1'b0, last_grant_q} + 4'd1;
        rot   = NREQ'({vld, vld} >> base);
        found = 1'b0;
        sum   = base;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = base + 4'(k);
            end
        end
        if (sum >= 4'(NREQ)) begin
            sum = sum - 4'(NREQ);
        end
        gnt_idx = 3'(sum);
    end

    always_comb begin
        req_ready_o = '0;
        add_in1_o   = '0;
        add_in2_o   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (found && (gnt_idx == 3'(i))) begin
                req_ready_o[i] = 1'b1;
                add_in1_o      = req_in1_i[i*32 +: 32];
                add_in2_o      = req_in2_i[i*32 +: 32];
            end
        end
        add_start_o = found;
    end

    assign emerge_v    = pv_q[LATENCY-1];
    assign emerge_t    = pt_q[LATENCY-1];
    assign res_valid_o = emerge_v && !reset_i;
    assign res_tag_o   = res_valid_o ? emerge_t : 3'd0;
    assign res_data_o  = res_valid_o ? add_result_i : 32'd0;
    assign res_inf_o   = res_valid_o && add_inf_i;
    assign res_zero_o  = res_valid_o && add_zero_i;
    assign in_flight_o = in_flight_q;
    assign err_o       = err_q;

    always_comb begin
        pv_d[0] = found;
        pt_d[0] = gnt_idx;
        for (int k = 1; k < LATENCY; k++) begin
            pv_d[k] = pv_q[k-1];
            pt_d[k] = pt_q[k-1];
        end
        last_grant_d = found ? gnt_idx : last_grant_q;
        in_flight_d  = in_flight_q + 3'(found) - 3'(res_valid_o);
        // The adder is not reset and may flush stale results; add_done is
        // only trusted once ign_q has counted down after reset.
        ign_d = (ign_q != '0) ? ign_q - IW'(1) : ign_q;
        err_d = err_q || ((ign_q == '0) && (add_done_i != emerge_v));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= 3'(NREQ - 1);
            pv_q         <= '0;
            pt_q         <= '0;
            in_flight_q  <= '0;
            err_q        <= 1'b0;
            ign_q        <= IW'(LATENCY);
        end else begin
            last_grant_q <= last_grant_d;
            pv_q         <= pv_d;
            pt_q         <= pt_d;
            in_flight_q  <= in_flight_d;
            err_q        <= err_d;
            ign_q        <= ign_d;
        end
    end

endmodule

// File: doc/posit_add_scheduler.md
POSIT_ADD_SCHEDULER -- requirements
Module: posit_add_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LATENCY, default 4, cycles from add_start sampled high to matching add_done high.
REQ-003 SHALL have clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have req_valid, input, NREQ, per-requester operation request.
REQ-006 SHALL have req_in1 and req_in2, inputs, NREQ*32, per-requester posit operands; slice i is bits [32i+31:32i].
REQ-007 SHALL have req_ready, output, NREQ, one-hot or zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have add_in1, add_in2 (output, 32) and add_start (output, 1), which drive the shared posit adder.
REQ-009 SHALL have add_result (input, 32) and add_inf, add_zero, add_done (inputs, 1 each), which return from the adder.
REQ-010 SHALL have res_valid (output, 1), res_tag (output, 3; requester index), res_data (output, 32) and res_inf, res_zero (outputs, 1 each).
REQ-011 SHALL have in_flight (output, 3; operations issued but not yet returned) and err (output, 1; sticky protocol error).

Function
REQ-012 SHALL arbitrate round-robin: priority starts at requester (last_grant+1) mod NREQ; at most one grant per cycle.
REQ-013 SHALL compute req_ready combinationally from req_valid and the priority pointer; req_ready SHALL NOT depend on add_done.
REQ-014 SHALL, on a grant to requester i, drive add_in1/add_in2 with slice i and add_start=1 in the same cycle; otherwise add_start=0 and add_in1/add_in2=0.
REQ-015 SHALL advance last_grant to i only on a cycle with a transfer; an idle cycle SHALL leave the pointer unchanged.
REQ-016 SHALL track each issue in a LATENCY-deep tag pipeline of {valid, tag}, shifted every cycle; the entry issued at cycle t emerges at cycle t+LATENCY.
REQ-017 SHALL assert res_valid=1 exactly when the emerging pipeline entry is valid, with res_tag from that entry and res_data/res_inf/res_zero passed through combinationally from add_result/add_inf/add_zero.
REQ-018 SHALL have no result backpressure; res_valid is a one-cycle pulse per operation, and back-to-back issues give back-to-back results in issue order.
REQ-019 SHALL set err when add_done disagrees with the emerging entry's valid bit in either direction, and hold err until reset.
REQ-020 SHALL ignore add_done for LATENCY cycles after reset deassertion, because the adder has no reset and may flush stale operations; such pulses SHALL neither set err nor produce res_valid.
REQ-021 SHALL update in_flight as +1 on issue and -1 on res_valid; a simultaneous issue and return leaves it unchanged; its maximum is LATENCY.
REQ-022 SHALL treat an X on any req_valid bit as 0.

Reset
REQ-023 SHALL, while reset=1, clear the tag pipeline, in_flight and err, set last_grant to NREQ-1 (so requester 0 has first priority), and force req_ready=0, add_start=0 and res_valid=0.
REQ-024 SHALL discard operations in flight when reset is asserted mid-operation: no res_valid for them, and err is not set by their late add_done.
REQ-025 SHALL drive res_tag=0 and res_data=0 whenever res_valid=0, including during reset.

Verification
REQ-026 SHALL cover the single request case: after reset, req_valid=0001 with in1=0x40000000 and in2=0x40000000 held for 1 cycle -> req_ready=0001 and add_start=1 at cycle 0; res_valid=1, res_tag=0, res_data=0x48000000 (with the real adder) at cycle 4; in_flight goes 1 then 0.
REQ-027 SHALL cover round-robin under full load: req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; res_tag sequence 0,1,2,3,0,1,2,3 on cycles 4..11; in_flight=4 steady.
REQ-028 SHALL cover a sparse pattern: req_valid=1010 held -> grants alternate 1,3,1,3; requesters 0 and 2 never granted; the pointer survives an inserted idle cycle.
REQ-029 SHALL cover reset mid-operation: 3 issues, reset pulsed on cycle 2 -> no res_valid, err=0, in_flight=0, and the first post-reset grant goes to requester 0.
REQ-030 SHALL cover a protocol error: an adder model injects a spurious add_done with an empty pipeline slot 10 cycles after reset -> err=1 from the next cycle until reset, res_valid stays 0.
